mvm_param: RTL and testbench

- Parametrised signed matrix-vector multiplier, successor to the fixed 8x8 serial-load MVM family.
- Computes y = A*x for an M x N matrix A and an N-vector x, both loaded serially over one data_in bus.
- Adds four capabilities over the fixed family: rectangular shapes, P parallel MAC lanes, an optional ReLU on results, and an explicit busy/outValid handshake.
- Sits between the stimulus/host loader and the result-collection logic, which captures M results after done.

---
 rtl/mvm_param.sv | 141 ++++++++++++++
 tb/tb_mvm_param.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mvm_param.sv
// mvm_param: parametrised signed M x N matrix-vector multiplier with P MAC lanes and optional ReLU
//   clk, reset                     : clock, synchronous active-high reset
//   loadMatrix, loadVector, start  : one-cycle command pulses, honoured only while idle
//   relu                           : latched on accepted start, clamps negative results to 0
//   data_in                        : serial load words (matrix row-major, then vector)
//   busy, done, outValid, data_out : status, completion pulse and result stream (row 0 first)
module mvm_param #(
    parameter int M = 8,
    parameter int N = 8,
    parameter int B = 12,
    parameter int P = 2,
    localparam int OW = 2*B + $clog2(N)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 loadMatrix,
    input  logic                 loadVector,
    input  logic                 start,
    input  logic                 relu,
    input  logic signed [B-1:0]  data_in,
    output logic                 busy,
    output logic                 done,
    output logic                 outValid,
    output logic signed [OW-1:0] data_out
);
    localparam int G   = M / P;
    localparam int AW  = $clog2(M*N);
    localparam int VW  = $clog2(N);
    localparam int YW  = $clog2(M);
    localparam int LW  = $clog2(M*N+1);
    localparam int GW  = $clog2(G+1);
    localparam int OCW = $clog2(M+1);

    if (M % P != 0) begin : g_chk
        $error("mvm_param: M must be a multiple of P");
    end

    typedef enum logic [2:0] {IDLE, LOAD_M, LOAD_V, COMPUTE, DRAIN, OUTPUT} state_t;
    state_t state;

    logic signed [B-1:0]    mat [M*N];
    logic signed [B-1:0]    vec [N];
    logic signed [OW-1:0]   y   [M];
    logic signed [2*B-1:0]  prod [P];
    logic                   pv, pfirst, relu_q, matValid, vecValid, dcnt;
    logic [GW-1:0]          gcnt, pg;
    logic [VW-1:0]          ccnt;
    logic [LW-1:0]          wcnt;
    logic [OCW-1:0]         ocnt;
    logic signed [OW-1:0]   ysel, rv;

    assign busy = state != IDLE;

    always_comb begin
        ysel = y[YW'(ocnt)];
        rv = (relu_q && ysel < 0) ? '0 : ysel;
    end

    // Two-stage lane pipeline: products registered in COMPUTE, accumulated into y one cycle later,
    // so the last accumulation lands in the first DRAIN cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            done <= 1'b0;
            outValid <= 1'b0;
            data_out <= '0;
            matValid <= 1'b0;
            vecValid <= 1'b0;
            pv <= 1'b0;
        end else begin
            done <= 1'b0;
            pv <= 1'b0;
            if (pv)
                for (int p = 0; p < P; p++)
                    y[YW'(int'(pg)*P + p)] <= (pfirst ? '0 : y[YW'(int'(pg)*P + p)]) + OW'(prod[p]);
            case (state)
                IDLE: begin
                    wcnt <= '0;
                    if (loadMatrix) state <= LOAD_M;
                    else if (loadVector) state <= LOAD_V;
                    else if (start && matValid && vecValid) begin
                        state <= COMPUTE;
                        ccnt <= '0;
                        gcnt <= '0;
                        dcnt <= 1'b0;
                        ocnt <= '0;
                        relu_q <= relu;
                    end
                end
                LOAD_M: begin
                    mat[AW'(wcnt)] <= data_in;
                    wcnt <= wcnt + 1'b1;
                    if (wcnt == LW'(M*N-1)) begin
                        state <= IDLE;
                        matValid <= 1'b1;
                    end
                end
                LOAD_V: begin
                    vec[VW'(wcnt)] <= data_in;
                    wcnt <= wcnt + 1'b1;
                    if (wcnt == LW'(N-1)) begin
                        state <= IDLE;
                        vecValid <= 1'b1;
                    end
                end
                COMPUTE: begin
                    pv <= 1'b1;
                    pfirst <= ccnt == '0;
                    pg <= gcnt;
                    for (int p = 0; p < P; p++)
                        prod[p] <= mat[AW'((int'(gcnt)*P + p)*N + int'(ccnt))] * vec[ccnt];
                    ccnt <= (ccnt == VW'(N-1)) ? '0 : ccnt + 1'b1;
                    if (ccnt == VW'(N-1)) begin
                        gcnt <= gcnt + 1'b1;
                        if (gcnt == GW'(G-1)) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    dcnt <= 1'b1;
                    if (dcnt) begin
                        outValid <= 1'b1;
                        data_out <= rv;
                        ocnt <= ocnt + 1'b1;
                        state <= OUTPUT;
                    end else done <= 1'b1;
                end
                OUTPUT: begin
                    if (ocnt == OCW'(M)) begin
                        outValid <= 1'b0;
                        data_out <= '0;
                        state <= IDLE;
                    end else begin
                        data_out <= rv;
                        ocnt <= ocnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mvm_param.sv
// tb_mvm_param: directed bench for mvm_param with a cycle-window behavioural model (8x8x12, P=2) and an M=6,N=5,B=8,P=3 sweep
module tb_mvm_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1, loadMatrix = 1'b0, loadVector = 1'b0, start = 1'b0, relu = 1'b0;
    logic signed [11:0] data_in = '0;
    logic busy, done, outValid;
    logic signed [26:0] data_out;

    logic r1 = 1'b1, lm1 = 1'b0, lv1 = 1'b0, st1 = 1'b0, rl1 = 1'b0;
    logic signed [7:0] d1 = '0;
    logic busy1, done1, ov1;
    logic signed [18:0] do1;

    mvm_param dut (.clk(clk), .reset(reset), .loadMatrix(loadMatrix), .loadVector(loadVector),
                   .start(start), .relu(relu), .data_in(data_in), .busy(busy), .done(done),
                   .outValid(outValid), .data_out(data_out));

    mvm_param #(.M(6), .N(5), .B(8), .P(3)) dut1 (.clk(clk), .reset(r1), .loadMatrix(lm1),
                   .loadVector(lv1), .start(st1), .relu(rl1), .data_in(d1), .busy(busy1),
                   .done(done1), .outValid(ov1), .data_out(do1));

    int nchk = 0, npass = 0;
    int cyc = 0;
    int wbuf [64];
    longint got [$];
    int done_cyc = -1, st_cyc = 0;
    bit sw_done = 1'b0;

    task automatic check(input string nm, input longint act, input longint exp);
        nchk++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Model: tracks busy/done/output windows in absolute cycle numbers; cycle c starts at edge c.
    int busy_end = -1, ld_kind = 0, ld_t = 0, tdone = -1000;
    bit mv = 1'b0, vv = 1'b0;
    longint am [64], xm [8], ym [8];

    always @(posedge clk) begin
        int c, len;
        longint s;
        cyc++;
        c = cyc - 1;
        if (reset) begin
            busy_end = c; mv = 1'b0; vv = 1'b0; tdone = -1000; ld_kind = 0;
        end else begin
            len = (ld_kind == 1) ? 64 : 8;
            if (ld_kind != 0 && c > ld_t && c <= ld_t + len) begin
                if (ld_kind == 1) am[c-ld_t-1] = longint'(data_in);
                else xm[c-ld_t-1] = longint'(data_in);
                if (c == ld_t + len) begin
                    if (ld_kind == 1) mv = 1'b1; else vv = 1'b1;
                    ld_kind = 0;
                end
            end
            if (c > busy_end) begin
                if (loadMatrix) begin ld_kind = 1; ld_t = c; busy_end = c + 64; end
                else if (loadVector) begin ld_kind = 2; ld_t = c; busy_end = c + 8; end
                else if (start && mv && vv) begin
                    for (int r = 0; r < 8; r++) begin
                        s = 0;
                        for (int k = 0; k < 8; k++) s += am[r*8+k] * xm[k];
                        ym[r] = (relu && s < 0) ? 0 : s;
                    end
                    tdone = c + 34;
                    busy_end = c + 34 + 8;
                end
            end
        end
    end

    always @(negedge clk) begin
        bit e_ov;
        if (cyc >= 1) begin
            e_ov = cyc > tdone && cyc <= tdone + 8;
            check("busy", busy, cyc <= busy_end);
            check("done", done, cyc == tdone);
            check("outValid", outValid, e_ov);
            check("data_out", data_out, e_ov ? ym[cyc-tdone-1] : 0);
            if (outValid) got.push_back(data_out);
            if (done && done_cyc < 0) done_cyc = cyc;
        end
    end

    task automatic send(input bit mat, input int n);
        if (mat) loadMatrix = 1'b1; else loadVector = 1'b1;
        tick;
        loadMatrix = 1'b0;
        loadVector = 1'b0;
        for (int i = 0; i < n; i++) begin
            data_in = 12'(wbuf[i]);
            tick;
        end
        data_in = '0;
    endtask

    task automatic wait_idle;
        for (int i = 0; i < 200 && busy; i++) tick;
        check("idle_timeout", busy, 0);
    endtask

    task automatic go(input bit r);
        got.delete();
        done_cyc = -1;
        start = 1'b1;
        relu = r;
        st_cyc = cyc;
        tick;
        start = 1'b0;
        relu = 1'b0;
        wait_idle();
    endtask

    initial begin : stim
        int xid [8];
        xid = '{1, -2, 3, -4, 5, -6, 7, -8};
        repeat (3) tick;
        reset = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ov", outValid, 0);
        check("rst_dout", data_out, 0);

        done_cyc = -1;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (5) tick;
        check("nold_busy", busy, 0);
        check("nold_done", done_cyc, -1);

        for (int i = 0; i < 64; i++) wbuf[i] = (i / 8 == i % 8) ? 1 : 0;
        send(1, 64);
        for (int i = 0; i < 8; i++) wbuf[i] = xid[i];
        send(0, 8);
        go(0);
        check("id_latency", done_cyc - st_cyc, 34);
        check("id_count", got.size(), 8);
        for (int i = 0; i < 8; i++) check($sformatf("id_y%0d", i), got[i], xid[i]);

        for (int i = 0; i < 8; i++) wbuf[i] = 1;
        send(0, 8);
        go(0);
        check("reuse_y0", got[0], 1);
        check("reuse_y7", got[7], 1);

        for (int i = 0; i < 64; i++) wbuf[i] = -2048;
        send(1, 64);
        send(0, 8);
        go(0);
        check("ext_y0", got[0], 33554432);
        check("ext_y5", got[5], 33554432);

        for (int i = 0; i < 64; i++) wbuf[i] = (i < 8) ? 1 : (i < 16) ? -1 : 0;
        send(1, 64);
        for (int i = 0; i < 8; i++) wbuf[i] = 5;
        send(0, 8);
        go(1);
        check("relu_y0", got[0], 40);
        check("relu_y1", got[1], 0);
        go(0);
        check("norelu_y1", got[1], -40);
        check("b2b_latency", done_cyc - st_cyc, 34);

        done_cyc = -1;
        loadMatrix = 1'b1;
        start = 1'b1;
        tick;
        loadMatrix = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 64; i++) begin
            data_in = 12'(2);
            tick;
        end
        data_in = '0;
        check("hz_nodone", done_cyc, -1);
        go(0);
        check("hz_y0", got[0], 80);

        got.delete();
        done_cyc = -1;
        start = 1'b1;
        st_cyc = cyc;
        tick;
        start = 1'b0;
        repeat (4) tick;
        loadVector = 1'b1;
        tick;
        loadVector = 1'b0;
        data_in = 12'(9);
        repeat (8) tick;
        data_in = '0;
        wait_idle();
        check("lvbusy_latency", done_cyc - st_cyc, 34);
        check("lvbusy_y3", got[3], 80);
        go(0);
        check("lvbusy_keep_y7", got[7], 80);

        done_cyc = -1;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (9) tick;
        reset = 1'b1;
        tick;
        check("rstc_busy", busy, 0);
        check("rstc_done", done, 0);
        check("rstc_ov", outValid, 0);
        check("rstc_dout", data_out, 0);
        reset = 1'b0;
        tick;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (40) tick;
        check("rstc_nostart_busy", busy, 0);
        check("rstc_nodone", done_cyc, -1);

        for (int i = 0; i < 2000 && !sw_done; i++) tick;
        check("sweep_finished", sw_done, 1);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

    initial begin : sweep
        int a1 [30], x1 [5], q1 [$];
        longint g1 [6];
        int sc, dc;
        repeat (3) tick;
        r1 = 1'b0;
        for (int i = 0; i < 30; i++) a1[i] = int'($urandom_range(255)) - 128;
        for (int i = 0; i < 5; i++) x1[i] = int'($urandom_range(255)) - 128;
        for (int r = 0; r < 6; r++) begin
            g1[r] = 0;
            for (int k = 0; k < 5; k++) g1[r] += longint'(a1[r*5+k]) * x1[k];
        end
        lm1 = 1'b1;
        tick;
        lm1 = 1'b0;
        for (int i = 0; i < 30; i++) begin d1 = 8'(a1[i]); tick; end
        lv1 = 1'b1;
        tick;
        lv1 = 1'b0;
        for (int i = 0; i < 5; i++) begin d1 = 8'(x1[i]); tick; end
        d1 = '0;
        st1 = 1'b1;
        sc = cyc;
        tick;
        st1 = 1'b0;
        dc = -1;
        for (int k = 0; k < 60; k++) begin
            if (done1 && dc < 0) dc = cyc;
            if (ov1) q1.push_back(int'(do1));
            tick;
        end
        check("sw_latency", dc - sc, 12);
        check("sw_count", q1.size(), 6);
        for (int i = 0; i < 6; i++) check($sformatf("sw_y%0d", i), q1[i], g1[i]);
        check("sw_idle", busy1, 0);
        sw_done = 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
